jump_pc_sequencer: RTL and testbench

- Owns the program counter for the single-issue RISC-V core.
- Each accepted instruction advances the PC by 4 or redirects it for JAL, JALR and taken conditional branches.
- After every redirect it holds the new PC and squashes wrong-path fetches for a programmable number of cycles.
- Sits between fetch, the immediate/sign-extension logic and the branch comparator; it builds J-, I- and B-type immediates internally.

---
 rtl/jump_pc_sequencer_if.sv | 28 ++
 rtl/jump_pc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_jump_pc_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/jump_pc_sequencer_if.sv
// Fetch-side bus of the jump/PC sequencer: instruction presentation in,
// program counter, redirect/flush control and link/trap results out.
interface jump_pc_sequencer_if;
    logic        instr_valid;
    logic [31:0] Instruction_code;
    logic [31:0] rs1_data;
    logic        branch_taken;
    logic        stall;
    logic [31:0] pc;
    logic        redirect;
    logic        flush;
    logic [31:0] link_addr;
    logic        link_we;
    logic        trap;
    logic [31:0] trap_addr;

    // Fetch/decode side: presents instructions, consumes PC and control
    modport master (
        output instr_valid, Instruction_code, rs1_data, branch_taken, stall,
        input  pc, redirect, flush, link_addr, link_we, trap, trap_addr
    );

    // Sequencer side
    modport slave (
        input  instr_valid, Instruction_code, rs1_data, branch_taken, stall,
        output pc, redirect, flush, link_addr, link_we, trap, trap_addr
    );
endinterface

// File: rtl/jump_pc_sequencer.sv
// Program counter owner for the single-issue RISC-V core.
// Advances by 4 per accepted instruction, redirects on JAL/JALR/taken
// branches, then squashes wrong-path fetches for FLUSH_CYCLES cycles.
// Optional feature: define JUMP_PC_SEQUENCER_MISALIGN_TRAP_EN to divert
// redirects with target[1]=1 to TRAP_VECTOR and report the faulting target.
module jump_pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic           clk,
    input  logic           reset,
    jump_pc_sequencer_if.slave bus
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [0:0] {S_RUN, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic        link_we_q, link_we_d;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] imm_j, imm_i, imm_b;
    logic        accept, is_jal, is_jalr, is_taken_br, take, link_wanted;
    logic [31:0] target;

    assign instr  = bus.Instruction_code;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];

    // Sign-extended J-, I- and B-type immediates
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    assign accept      = (state_q == S_RUN) && bus.instr_valid && !bus.stall;
    assign is_jal      = (opcode == OP_JAL);
    assign is_jalr     = (opcode == OP_JALR);
    assign is_taken_br = (opcode == OP_BRANCH) && bus.branch_taken;
    assign take        = is_jal || is_jalr || is_taken_br;
    assign link_wanted = (is_jal || is_jalr) && (rd != 5'd0);

    // Redirect target selection; JALR clears bit 0 of its sum
    always_comb begin
        target = pc_q + imm_b;
        if (is_jal) begin
            target = pc_q + imm_j;
        end else if (is_jalr) begin
            target = (bus.rs1_data + imm_i) & ~32'h1;
        end
    end

`ifdef JUMP_PC_SEQUENCER_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;
`else
    logic        unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
`endif

    // Next-state and next-output logic for the RUN/FLUSH sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        redirect_d  = 1'b0;
        link_we_d   = 1'b0;
        link_addr_d = link_addr_q;
`ifdef JUMP_PC_SEQUENCER_MISALIGN_TRAP_EN
        trap_d      = 1'b0;
        trap_addr_d = trap_addr_q;
`endif
        case (state_q)
            S_RUN: begin
                if (accept) begin
                    if (take) begin
                        pc_d       = target;
                        redirect_d = 1'b1;
                        cnt_d      = FLUSH_LOAD;
                        state_d    = S_FLUSH;
`ifdef JUMP_PC_SEQUENCER_MISALIGN_TRAP_EN
                        if (target[1]) begin
                            // Misaligned target: trap instead, no link write
                            pc_d        = TRAP_VECTOR;
                            trap_d      = 1'b1;
                            trap_addr_d = target;
                        end else if (link_wanted) begin
                            link_we_d   = 1'b1;
                            link_addr_d = pc_q + 32'd4;
                        end
`else
                        if (link_wanted) begin
                            link_we_d   = 1'b1;
                            link_addr_d = pc_q + 32'd4;
                        end
`endif
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // State and output registers; reset has priority in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            cnt_q       <= 3'd0;
            pc_q        <= RESET_PC;
            redirect_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_addr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            link_we_q   <= link_we_d;
            link_addr_q <= link_addr_d;
        end
    end

`ifdef JUMP_PC_SEQUENCER_MISALIGN_TRAP_EN
    // Trap pulse and held faulting address
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q      <= 1'b0;
            trap_addr_q <= 32'd0;
        end else begin
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
        end
    end
    assign bus.trap      = trap_q;
    assign bus.trap_addr = trap_addr_q;
`else
    assign bus.trap      = 1'b0;
    assign bus.trap_addr = 32'd0;
`endif

    assign bus.pc        = pc_q;
    assign bus.redirect  = redirect_q;
    assign bus.flush     = (state_q == S_FLUSH);
    assign bus.link_addr = link_addr_q;
    assign bus.link_we   = link_we_q;

endmodule

// File: tb/tb_jump_pc_sequencer.sv
// Directed testbench for jump_pc_sequencer (default parameters).
module tb_jump_pc_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL_P8   = 32'h0080_00EF; // jal x1,+8
    localparam logic [31:0] JAL_M4   = 32'hFFDF_F06F; // jal x0,-4
    localparam logic [31:0] BEQ_P16  = 32'h0000_0863; // beq +16
    localparam logic [31:0] JALR_MIS = 32'h0032_80E7; // jalr x1,3(x5)
    localparam logic [31:0] JALR_X0  = 32'h0002_8067; // jalr x0,0(x5)

    jump_pc_sequencer_if bus();

    jump_pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
        $display("[TB] t=%0t pc=%h redir=%b flush=%b link_we=%b link_addr=%h trap=%b trap_addr=%h",
                 $time, bus.pc, bus.redirect, bus.flush, bus.link_we, bus.link_addr,
                 bus.trap, bus.trap_addr);
    endtask

    task automatic idle();
        bus.instr_valid      = 1'b0;
        bus.Instruction_code = NOP;
        bus.branch_taken     = 1'b0;
        bus.stall            = 1'b0;
    endtask

    // Move pc to addr via jalr x0 and let the flush drain
    task automatic goto_pc(input logic [31:0] addr);
        bus.instr_valid      = 1'b1;
        bus.Instruction_code = JALR_X0;
        bus.rs1_data         = addr;
        step();
        idle();
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        bus.rs1_data = 32'd0;
        step();
        step();
        tests_run++; if (bus.pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h exp %h", bus.pc, 32'h0); end
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %b exp 0", bus.flush); end
        tests_run++; if (bus.redirect !== 1'b0) begin tests_failed++; $display("FAIL reset_redirect: got %b exp 0", bus.redirect); end
        tests_run++; if (bus.link_we !== 1'b0) begin tests_failed++; $display("FAIL reset_link_we: got %b exp 0", bus.link_we); end
        tests_run++; if (bus.link_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_link_addr: got %h exp 0", bus.link_addr); end
        tests_run++; if (bus.trap !== 1'b0 || bus.trap_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_trap: got %b/%h exp 0/0", bus.trap, bus.trap_addr); end
        reset = 1'b0;
    endtask

    task automatic test_jal_link();
        goto_pc(32'h100);
        tests_run++; if (bus.pc !== 32'h100) begin tests_failed++; $display("FAIL goto_100: got %h exp %h", bus.pc, 32'h100); end
        bus.instr_valid = 1'b1; bus.Instruction_code = JAL_P8;
        step();
        idle();
        tests_run++; if (bus.pc !== 32'h108) begin tests_failed++; $display("FAIL jal_pc: got %h exp %h", bus.pc, 32'h108); end
        tests_run++; if (bus.redirect !== 1'b1) begin tests_failed++; $display("FAIL jal_redirect: got %b exp 1", bus.redirect); end
        tests_run++; if (bus.link_we !== 1'b1) begin tests_failed++; $display("FAIL jal_link_we: got %b exp 1", bus.link_we); end
        tests_run++; if (bus.link_addr !== 32'h104) begin tests_failed++; $display("FAIL jal_link_addr: got %h exp %h", bus.link_addr, 32'h104); end
        tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL jal_flush1: got %b exp 1", bus.flush); end
        step();
        tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL jal_flush2: got %b exp 1", bus.flush); end
        tests_run++; if (bus.redirect !== 1'b0 || bus.link_we !== 1'b0) begin tests_failed++; $display("FAIL jal_pulse_width: got redirect=%b link_we=%b exp 0/0", bus.redirect, bus.link_we); end
        step();
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL jal_flush_end: got %b exp 0", bus.flush); end
        tests_run++; if (bus.pc !== 32'h108) begin tests_failed++; $display("FAIL jal_pc_hold: got %h exp %h", bus.pc, 32'h108); end
    endtask

    task automatic test_jal_wrap();
        goto_pc(32'h0);
        bus.instr_valid = 1'b1; bus.Instruction_code = JAL_M4;
        step();
        idle();
        tests_run++; if (bus.pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc: got %h exp %h", bus.pc, 32'hFFFF_FFFC); end
        tests_run++; if (bus.link_we !== 1'b0) begin tests_failed++; $display("FAIL wrap_link_we: got %b exp 0", bus.link_we); end
        tests_run++; if (bus.link_addr !== 32'h104) begin tests_failed++; $display("FAIL wrap_link_addr_kept: got %h exp %h", bus.link_addr, 32'h104); end
        tests_run++; if (bus.redirect !== 1'b1) begin tests_failed++; $display("FAIL wrap_redirect: got %b exp 1", bus.redirect); end
        step();
        step();
    endtask

    task automatic test_branch();
        goto_pc(32'h40);
        bus.instr_valid = 1'b1; bus.Instruction_code = BEQ_P16; bus.branch_taken = 1'b1;
        step();
        idle();
        tests_run++; if (bus.pc !== 32'h50) begin tests_failed++; $display("FAIL br_taken_pc: got %h exp %h", bus.pc, 32'h50); end
        tests_run++; if (bus.redirect !== 1'b1 || bus.flush !== 1'b1) begin tests_failed++; $display("FAIL br_taken_ctl: got redirect=%b flush=%b exp 1/1", bus.redirect, bus.flush); end
        tests_run++; if (bus.link_we !== 1'b0) begin tests_failed++; $display("FAIL br_taken_link_we: got %b exp 0", bus.link_we); end
        step();
        tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL br_flush2: got %b exp 1", bus.flush); end
        step();
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL br_flush_end: got %b exp 0", bus.flush); end
        goto_pc(32'h40);
        bus.instr_valid = 1'b1; bus.Instruction_code = BEQ_P16; bus.branch_taken = 1'b0;
        step();
        idle();
        tests_run++; if (bus.pc !== 32'h44) begin tests_failed++; $display("FAIL br_nt_pc: got %h exp %h", bus.pc, 32'h44); end
        tests_run++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b0) begin tests_failed++; $display("FAIL br_nt_ctl: got redirect=%b flush=%b exp 0/0", bus.redirect, bus.flush); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        exp_pc = 32'h44;
        bus.instr_valid = 1'b1; bus.Instruction_code = NOP;
        for (int k = 0; k < 3; k++) begin
            exp_pc = exp_pc + 32'd4;
            step();
            tests_run++; if (bus.pc !== exp_pc) begin tests_failed++; $display("FAIL b2b_pc%0d: got %h exp %h", k, bus.pc, exp_pc); end
        end
        idle();
    endtask

    task automatic test_jalr_misaligned();
        goto_pc(32'h300);
        bus.instr_valid = 1'b1; bus.Instruction_code = JALR_MIS; bus.rs1_data = 32'h200;
        step();
        idle();
`ifdef JUMP_PC_SEQUENCER_MISALIGN_TRAP_EN
        tests_run++; if (bus.pc !== 32'h100) begin tests_failed++; $display("FAIL mis_pc: got %h exp %h", bus.pc, 32'h100); end
        tests_run++; if (bus.trap !== 1'b1 || bus.trap_addr !== 32'h202) begin tests_failed++; $display("FAIL mis_trap: got %b/%h exp 1/%h", bus.trap, bus.trap_addr, 32'h202); end
        tests_run++; if (bus.link_we !== 1'b0) begin tests_failed++; $display("FAIL mis_link_we: got %b exp 0", bus.link_we); end
        step();
        tests_run++; if (bus.trap !== 1'b0 || bus.trap_addr !== 32'h202) begin tests_failed++; $display("FAIL mis_trap_hold: got %b/%h exp 0/%h", bus.trap, bus.trap_addr, 32'h202); end
`else
        tests_run++; if (bus.pc !== 32'h202) begin tests_failed++; $display("FAIL mis_pc: got %h exp %h", bus.pc, 32'h202); end
        tests_run++; if (bus.link_we !== 1'b1 || bus.link_addr !== 32'h304) begin tests_failed++; $display("FAIL mis_link: got %b/%h exp 1/%h", bus.link_we, bus.link_addr, 32'h304); end
        tests_run++; if (bus.trap !== 1'b0 || bus.trap_addr !== 32'h0) begin tests_failed++; $display("FAIL mis_trap_tied: got %b/%h exp 0/0", bus.trap, bus.trap_addr); end
        step();
`endif
        tests_run++; if (bus.redirect !== 1'b0) begin tests_failed++; $display("FAIL mis_redirect_width: got %b exp 0", bus.redirect); end
        step();
    endtask

    task automatic test_stall_and_mask();
        goto_pc(32'h100);
        bus.instr_valid = 1'b1; bus.Instruction_code = JAL_P8; bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++; if (bus.pc !== 32'h100 || bus.redirect !== 1'b0) begin tests_failed++; $display("FAIL stall_hold%0d: got pc=%h redirect=%b exp %h/0", k, bus.pc, bus.redirect, 32'h100); end
        end
        bus.stall = 1'b0;
        step();
        tests_run++; if (bus.pc !== 32'h108 || bus.redirect !== 1'b1) begin tests_failed++; $display("FAIL stall_release: got pc=%h redirect=%b exp %h/1", bus.pc, bus.redirect, 32'h108); end
        // Keep presenting a valid JAL during FLUSH: it must be ignored
        for (int k = 0; k < 2; k++) begin
            step();
            tests_run++; if (bus.pc !== 32'h108 || bus.redirect !== 1'b0) begin tests_failed++; $display("FAIL flush_mask%0d: got pc=%h redirect=%b exp %h/0", k, bus.pc, bus.redirect, 32'h108); end
        end
        // Back in RUN the same JAL is now accepted (first acceptance at FLUSH_CYCLES+1)
        step();
        idle();
        tests_run++; if (bus.pc !== 32'h110 || bus.link_addr !== 32'h10C) begin tests_failed++; $display("FAIL flush_reaccept: got pc=%h link=%h exp %h/%h", bus.pc, bus.link_addr, 32'h110, 32'h10C); end
        step();
        step();
    endtask

    task automatic test_reset_mid_flush();
        goto_pc(32'h100);
        bus.instr_valid = 1'b1; bus.Instruction_code = JAL_P8;
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++; if (bus.pc !== 32'h0 || bus.flush !== 1'b0) begin tests_failed++; $display("FAIL rst_flush_pc: got pc=%h flush=%b exp 0/0", bus.pc, bus.flush); end
        tests_run++; if (bus.redirect !== 1'b0 || bus.link_we !== 1'b0 || bus.trap !== 1'b0) begin tests_failed++; $display("FAIL rst_flush_pulses: got %b%b%b exp 000", bus.redirect, bus.link_we, bus.trap); end
        tests_run++; if (bus.link_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_flush_link: got %h exp 0", bus.link_addr); end
        bus.instr_valid = 1'b1; bus.Instruction_code = NOP;
        step();
        idle();
        tests_run++; if (bus.pc !== 32'h4) begin tests_failed++; $display("FAIL rst_flush_run: got %h exp %h", bus.pc, 32'h4); end
    endtask

    initial begin
        test_reset();
        test_jal_link();
        test_jal_wrap();
        test_branch();
        test_back_to_back();
        test_jalr_misaligned();
        test_stall_and_mask();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
